// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - LEGv8 program counter with fetch handshake, retire counter and sticky halt
module pc_update_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 resetl,
    input  logic [63:0]          BusImm,
    input  logic                 Branch,
    input  logic                 Uncondbranch,
    input  logic                 Zero,
    input  logic                 Halt,
    input  logic                 imem_ack,
    output logic                 imem_req,
    output logic [63:0]          CurrentPC,
    output logic                 instr_valid,
    output logic                 branch_taken,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [63:0]          pc_q, pc_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic                 halted_q, halted_d;
    logic                 taken;

    assign taken = Uncondbranch | (Branch & Zero);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        halted_d  = halted_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instret_d = instret_q + CNT_WIDTH'(1);
                // Halt wins over any redirect: the PC stays on the halt instruction.
                if (Halt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    pc_d    = taken ? (pc_q + BusImm) : (pc_q + 64'd4);
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
        end
    end

    // The state register already sits in FETCH during reset, so the request is gated by resetl.
    assign imem_req     = resetl & (state_q == ST_FETCH);
    assign instr_valid  = (state_q == ST_EXEC);
    assign branch_taken = instr_valid & taken & ~Halt;
    assign CurrentPC    = pc_q;
    assign instret      = instret_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - scoreboard bench for pc_update_unit
module tb_pc_update_unit;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] BusImm;
    logic        Branch, Uncondbranch, Zero, Halt, imem_ack;
    logic        imem_req, instr_valid, branch_taken, halted;
    logic [63:0] CurrentPC;
    logic [31:0] instret;

    pc_update_unit #(.RESET_PC(64'h0), .CNT_WIDTH(32)) dut (
        .CLK(CLK), .resetl(resetl), .BusImm(BusImm), .Branch(Branch),
        .Uncondbranch(Uncondbranch), .Zero(Zero), .Halt(Halt), .imem_ack(imem_ack),
        .imem_req(imem_req), .CurrentPC(CurrentPC), .instr_valid(instr_valid),
        .branch_taken(branch_taken), .halted(halted), .instret(instret)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every EXEC cycle is matched against the oldest queued expectation.
    always @(negedge CLK) begin
        if (instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_exec: got pc %h expected no instruction", CurrentPC);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("exec_pc", CurrentPC, e.pc);
                check("exec_branch_taken", {63'b0, branch_taken}, {63'b0, e.taken});
                check("exec_instret", {32'b0, instret}, {32'b0, e.cnt});
            end
        end
    end

    // Called at a negedge while in FETCH; returns at the negedge after EXEC.
    task automatic run_instr(input logic [63:0] imm, input logic br, input logic ub,
                             input logic z, input logic hlt, input int delay);
        exp_t e;
        logic tk;
        tk = ub | (br & z);
        e.pc = exp_pc; e.taken = tk & ~hlt; e.cnt = exp_cnt;
        sb.push_back(e);
        if (!hlt) exp_pc = tk ? exp_pc + imm : exp_pc + 64'd4;
        exp_cnt = exp_cnt + 32'd1;
        BusImm = imm; Branch = br; Uncondbranch = ub; Zero = z; Halt = hlt;
        imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            check("wait_req", {63'b0, imem_req}, 64'd1);
            check("wait_pc", CurrentPC, e.pc);
            check("wait_instret", {32'b0, instret}, {32'b0, e.cnt});
        end
        imem_ack = 1'b1;
        @(negedge CLK);
        check("exec_latency", {63'b0, instr_valid}, 64'd1);
        check("exec_req_low", {63'b0, imem_req}, 64'd0);
        imem_ack = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        resetl = 1'b0; BusImm = '0; Branch = 0; Uncondbranch = 0; Zero = 0; Halt = 0; imem_ack = 1'b1;
        exp_pc = 64'h0; exp_cnt = 32'd0;
        repeat (2) @(negedge CLK);
        check("rst_pc", CurrentPC, 64'h0);
        check("rst_req", {63'b0, imem_req}, 64'd0);
        check("rst_valid", {63'b0, instr_valid}, 64'd0);
        check("rst_halted", {63'b0, halted}, 64'd0);
        check("rst_instret", {32'b0, instret}, 64'd0);
        resetl = 1'b1;
        #1;
        check("first_req", {63'b0, imem_req}, 64'd1);

        run_instr(64'h0, 0, 0, 0, 0, 0);                       // pc 0
        run_instr(64'h0, 0, 0, 0, 0, 0);                       // pc 4
        run_instr(64'h0, 0, 0, 0, 0, 0);                       // pc 8
        check("three_instret", {32'b0, instret}, 64'd3);
        run_instr(64'h34, 0, 1, 0, 0, 0);                      // 0xC -> 0x40
        run_instr(64'h100, 0, 1, 0, 0, 0);                     // 0x40 -> 0x140
        check("uncond_target", CurrentPC, 64'h140);
        run_instr(64'hC0, 0, 1, 0, 0, 0);                      // 0x140 -> 0x200
        run_instr(64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 1, 0, 0);     // cbz taken -> 0x1F0
        check("cbz_taken_target", CurrentPC, 64'h1F0);
        run_instr(64'h10, 0, 1, 0, 0, 0);                      // 0x1F0 -> 0x200
        run_instr(64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 0, 0, 0);     // cbz not taken -> 0x204
        check("cbz_fall_target", CurrentPC, 64'h204);
        run_instr(64'h0, 0, 0, 0, 0, 5);                       // 0x204 with 5-cycle ack delay
        run_instr(64'hFFFF_FFFF_FFFF_FDF4, 1, 1, 0, 0, 0);     // both branches -> 0xFFFF_FFFF_FFFF_FFFC
        check("near_wrap_pc", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
        run_instr(64'h0, 0, 0, 0, 0, 0);                       // wraps to 0
        check("wrap_pc", CurrentPC, 64'h0);
        run_instr(64'h80, 0, 1, 0, 0, 0);                      // 0 -> 0x80
        run_instr(64'h100, 0, 1, 0, 1, 0);                     // halt beats branch at 0x80

        check("halted_flag", {63'b0, halted}, 64'd1);
        check("halted_pc", CurrentPC, 64'h80);
        check("halted_instret", {32'b0, instret}, {32'b0, exp_cnt});
        for (int i = 0; i < 4; i++) begin
            imem_ack = i[0];
            Uncondbranch = 1'b1;
            @(negedge CLK);
            check("halt_req", {63'b0, imem_req}, 64'd0);
            check("halt_valid", {63'b0, instr_valid}, 64'd0);
            check("halt_taken", {63'b0, branch_taken}, 64'd0);
            check("halt_pc_frozen", CurrentPC, 64'h80);
        end
        check("halt_instret_frozen", {32'b0, instret}, 64'd14);

        resetl = 1'b0;
        @(negedge CLK);
        check("rst2_halted", {63'b0, halted}, 64'd0);
        resetl = 1'b1;
        exp_pc = 64'h0; exp_cnt = 32'd0;
        run_instr(64'h0, 0, 0, 0, 0, 0);
        check("post_rst_pc", CurrentPC, 64'h4);
        check("post_rst_instret", {32'b0, instret}, 64'd1);
        imem_ack = 1'b0;
        #2;
        resetl = 1'b0;
        #1;
        check("async_rst_pc", CurrentPC, 64'h0);
        check("async_rst_req", {63'b0, imem_req}, 64'd0);
        check("async_rst_instret", {32'b0, instret}, 64'd0);
        check("async_rst_valid", {63'b0, instr_valid}, 64'd0);
        @(negedge CLK);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
